// File: rtl/block_ram_pkg.sv
// Shared defaults and lane type for the decompressor output-stage block RAM.
// A lane is 8 data bits plus one valid flag.
package block_ram_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int LANES_DEF  = 8;
    localparam int LANE_W_DEF = 9;

    typedef logic [LANE_W_DEF-1:0] lane_t;

endpackage

// File: rtl/block_ram.sv
// Simple dual-port, single-clock block RAM with per-lane write enables on port A
// and a registered, read-first synchronous read on port B.
module block_ram
    import block_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       addra,
    input  logic [LANES*LANE_W-1:0] dina,
    input  logic                    ena,
    input  logic [LANES-1:0]        wea,
    input  logic [ADDR_W-1:0]       addrb,
    input  logic                    enb,
    output logic [LANES*LANE_W-1:0] doutb
);

    localparam int WordW = LANES * LANE_W;
    localparam int Depth = 2 ** ADDR_W;

    // Zero contents at time 0: the output stage treats a cleared valid flag as empty.
    logic [WordW-1:0] memArray [Depth] = '{default: '0};

    logic [LANES-1:0] laneWe;
    logic [WordW-1:0] doutb_q;
    logic [WordW-1:0] doutb_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign laneWe[i] = ena & wea[i];
    end

    // Port A ignores rst_n so writes keep flowing while the read register is held in reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (laneWe[i]) begin
                memArray[addra][i*LANE_W +: LANE_W] <= dina[i*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        doutb_d = doutb_q;
        if (enb) begin
            doutb_d = memArray[addrb];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            doutb_q <= '0;
        end else begin
            doutb_q <= doutb_d;
        end
    end

    assign doutb = doutb_q;

endmodule

// File: tb/tb_block_ram.sv
// Directed scoreboard bench for block_ram: stimulus queues expected read words,
// a separate monitor compares doutb after each edge that carries a check.
module tb_block_ram;
    import block_ram_pkg::*;

    typedef struct {
        string       name;
        logic [71:0] expWord;
    } expEntry_t;

    logic        clk;
    logic        rst_n;
    logic [8:0]  addra;
    logic [71:0] dina;
    logic        ena;
    logic [7:0]  wea;
    logic [8:0]  addrb;
    logic        enb;
    logic [71:0] doutb;

    bit          chk;
    expEntry_t   scoreboard[$];
    int          checks;
    int          passes;

    localparam logic [71:0] WordFull = {lane_t'(9'h123), lane_t'(9'h145), lane_t'(9'h167), lane_t'(9'h189),
                                        lane_t'(9'h1AB), lane_t'(9'h1CD), lane_t'(9'h1EF), lane_t'(9'h101)};
    localparam logic [71:0] WordMasked = {lane_t'(9'h123), lane_t'(9'h145), lane_t'(9'h167), lane_t'(9'h189),
                                          lane_t'(9'h1FF), lane_t'(9'h1FF), lane_t'(9'h1FF), lane_t'(9'h1FF)};
    localparam logic [71:0] WordAA    = 72'hAAAAAAAAAAAAAAAAAA;
    localparam logic [71:0] WordRst   = 72'h123456789ABCDEF012;
    localparam logic [71:0] WordTop   = {lane_t'(9'h1FF), 63'h0};
    localparam logic [71:0] AllOnes   = {72{1'b1}};

    block_ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addra (addra),
        .dina  (dina),
        .ena   (ena),
        .wea   (wea),
        .addrb (addrb),
        .enb   (enb),
        .doutb (doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; when doCheck is set the word expected after the next edge is queued.
    task automatic applyStimulus(input logic rstN, input logic wEn, input logic [8:0] wAddr,
                                 input logic [71:0] wData, input logic [7:0] wMask,
                                 input logic rEn, input logic [8:0] rAddr,
                                 input bit doCheck, input string name, input logic [71:0] expWord);
        expEntry_t e;
        @(negedge clk);
        rst_n = rstN;
        ena   = wEn;
        addra = wAddr;
        dina  = wData;
        wea   = wMask;
        enb   = rEn;
        addrb = rAddr;
        chk   = doCheck;
        if (doCheck) begin
            e.name    = name;
            e.expWord = expWord;
            scoreboard.push_back(e);
        end
    endtask

    task automatic checkOutput(input string name, input logic [71:0] expWord);
        checks++;
        if (doutb !== expWord) begin
            $display("[TB] FAIL %s: doutb=%h expected=%h", name, doutb, expWord);
        end else begin
            passes++;
        end
    endtask

    initial begin : monitor
        bit sampled;
        expEntry_t e;
        forever begin
            @(posedge clk);
            sampled = chk;
            #1;
            if (sampled) begin
                if (scoreboard.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL scoreboard_underflow: doutb=%h expected=<queued entry>", doutb);
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput(e.name, e.expWord);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: sim time=%0t limit=200000", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        checks = 0;
        passes = 0;
        chk    = 1'b0;
        rst_n  = 1'b0;
        ena    = 1'b0;
        wea    = '0;
        addra  = '0;
        dina   = '0;
        enb    = 1'b0;
        addrb  = '0;

        applyStimulus(1'b0, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd3,   1'b1, "reset_state", 72'h0);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd0,   1'b1, "powerup_addr0", 72'h0);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd1,   1'b1, "powerup_addr1", 72'h0);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd511, 1'b1, "powerup_addr511", 72'h0);

        applyStimulus(1'b1, 1'b1, 9'd5, WordFull, 8'hFF, 1'b0, 9'd0, 1'b0, "", 72'h0);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd5,   1'b1, "full_word", WordFull);

        applyStimulus(1'b1, 1'b1, 9'd5, AllOnes, 8'h0F, 1'b0, 9'd0, 1'b0, "", 72'h0);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd5,   1'b1, "lane_mask", WordMasked);
        applyStimulus(1'b1, 1'b0, 9'd5,   72'h0, 8'hFF, 1'b1, 9'd5,   1'b1, "ena_low_same_cycle", WordMasked);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd5,   1'b1, "ena_low_no_write", WordMasked);

        applyStimulus(1'b1, 1'b1, 9'd7,  WordAA, 8'hFF, 1'b1, 9'd7,   1'b1, "collision_old", 72'h0);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd7,   1'b1, "collision_new", WordAA);

        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd5,   1'b1, "read_addr5", WordMasked);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b0, 9'd7,   1'b1, "enb_hold1", WordMasked);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b0, 9'd7,   1'b1, "enb_hold2", WordMasked);

        applyStimulus(1'b0, 1'b1, 9'd9, WordRst, 8'hFF, 1'b1, 9'd7,   1'b1, "reset_clears", 72'h0);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd5,   1'b1, "post_reset_addr5", WordMasked);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd9,   1'b1, "write_during_reset", WordRst);

        applyStimulus(1'b1, 1'b1, 9'd511, AllOnes, 8'h80, 1'b0, 9'd0, 1'b0, "", 72'h0);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd511, 1'b1, "top_addr_lane7", WordTop);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b1, 9'd0,   1'b1, "addr0_untouched", 72'h0);

        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b0, 9'd0,   1'b0, "", 72'h0);
        applyStimulus(1'b1, 1'b0, 9'd0,   72'h0, 8'h00, 1'b0, 9'd0,   1'b0, "", 72'h0);
        @(posedge clk);
        #2;

        checks++;
        if (scoreboard.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: pending=%0d expected=0", scoreboard.size());
        end else begin
            passes++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
